if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, SHALL be the instruction word inserted as a bubble.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 imem_req  output  1  SHALL be the instruction memory request.
REQ-006 imem_addr  output  32  SHALL be the fetch address; stable while imem_req high until ack.
REQ-007 imem_ack  input  1  SHALL mark imem_rdata valid this cycle; legal in the same cycle as imem_req.
REQ-008 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-009 stall_id  input  1  SHALL hold the IF/ID register (decode not accepting).
REQ-010 flush_id  input  1  SHALL replace the IF/ID contents with a bubble.
REQ-011 redirect  input  1  SHALL request a change of fetch path (taken beq or jump).
REQ-012 redirect_pc  input  32  SHALL be the new fetch address; bits [1:0] ignored, forced 2'b00.
REQ-013 instr_id  output  32  SHALL be the registered instruction feeding the decode controller.
REQ-014 pc4_id  output  32  SHALL be the registered fetch address + 4 of instr_id.
REQ-015 valid_id  output  1  SHALL be high when instr_id is a real fetched instruction.

Function
REQ-016 State machine SHALL have states FETCH, HOLD, DISCARD.
REQ-017 FETCH: imem_req=1, imem_addr=pc.
REQ-018 FETCH, ack, no stall_id/flush_id/redirect: instr_id<=imem_rdata, pc4_id<=pc+4, valid_id<=1, pc<=pc+4, stay FETCH.
REQ-019 FETCH, ack, stall_id, no redirect: IF/ID holds; imem_rdata and pc+4 captured in one-entry skid buffer; pc<=pc+4; go HOLD.
REQ-020 FETCH, no ack, no redirect: pc holds; if stall_id, IF/ID holds, else IF/ID loads bubble (instr_id=NOP_INSTR, valid_id=0, pc4_id unchanged).
REQ-021 HOLD: imem_req=0; on stall_id low, IF/ID loads skid buffer with valid_id=1, go FETCH.
REQ-022 redirect in FETCH with ack same cycle: rdata dropped, pc<=redirect_pc, go FETCH.
REQ-023 redirect in FETCH without ack: pc<=redirect_pc, go DISCARD; imem_addr keeps old address, imem_req stays 1.
REQ-024 DISCARD: imem_req=1, imem_addr=last requested address; on ack rdata dropped, go FETCH (new pc); redirect in DISCARD updates pc only.
REQ-025 redirect in HOLD: skid buffer dropped, pc<=redirect_pc, go FETCH.
REQ-026 redirect SHALL always load a bubble into IF/ID the same edge, overriding stall_id.
REQ-027 flush_id without redirect: IF/ID bubble, overrides stall_id; fetch path unaffected except an ack in that cycle is treated as stall_id=0 per REQ-018 but with bubble written — i.e. instruction dropped, pc<=pc+4; in HOLD flush_id drops buffer, go FETCH.
REQ-028 Priority: redirect > flush_id > stall_id.
REQ-029 PC arithmetic SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-030 No combinational path from imem_ack/imem_rdata to instr_id/pc4_id/valid_id.

Reset
REQ-031 rst_n low SHALL immediately force: pc=RESET_PC, state=FETCH, instr_id=NOP_INSTR, pc4_id=0, valid_id=0, skid buffer empty.
REQ-032 Reset mid-request SHALL abandon the access; first post-reset request uses RESET_PC.
REQ-033 imem_req SHALL be 0 while rst_n low.

Verification
REQ-034 Zero-wait ack every cycle from reset -> imem_addr 0,4,8,...; instr_id follows one cycle later, valid_id=1, pc4_id=addr+4.
REQ-035 ack with stall_id high 3 cycles at addr 0x10 -> imem_req=0 during HOLD, IF/ID held, on release instr_id=word@0x10, pc4_id=0x14, next addr 0x14.
REQ-036 redirect to 0x40 while addr 0x08 pending 2-cycle wait -> addr stays 0x08 until ack, data dropped, next addr 0x40, valid_id=0 until 0x40 word.
REQ-037 redirect and stall_id same cycle -> instr_id=NOP_INSTR, valid_id=0, next addr redirect_pc.
REQ-038 redirect_pc=0xFFFF_FFFF -> addr 0xFFFF_FFFC, then 0x0000_0000.
REQ-039 rst_n low in DISCARD -> outputs at reset values immediately, first fetch at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a one-entry skid buffer.
//
// Fetches one 32-bit instruction per accepted memory access and hands it to
// decode through the IF/ID register (instr_id / pc4_id / valid_id).
//
// Ports
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   imem_req        : instruction memory request (low while in reset / HOLD)
//   imem_addr       : fetch address, stable while imem_req is high until ack
//   imem_ack        : imem_rdata valid this cycle (may coincide with imem_req)
//   imem_rdata      : fetched instruction word
//   stall_id        : decode not accepting, hold IF/ID
//   flush_id        : replace IF/ID contents with a bubble
//   redirect        : change fetch path (taken branch or jump)
//   redirect_pc     : new fetch address, bits [1:0] forced to zero
//   instr_id        : registered instruction for decode
//   pc4_id          : registered fetch address + 4 of instr_id
//   valid_id        : instr_id is a real fetched instruction
//   state_dbg       : current FSM state (0 FETCH, 1 HOLD, 2 DISCARD)
//
// Memory handshake: a transfer completes on any rising edge where imem_req
// and imem_ack are both high; imem_addr does not change between the edge
// that raises imem_req and that completing edge.
// ----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_id,
  input  logic        flush_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_id,
  output logic [31:0] pc4_id,
  output logic        valid_id,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;     // address still outstanding while in DISCARD
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;

  logic [31:0] pc_next;
  logic [31:0] redirect_aligned;

  // 32-bit add wraps naturally modulo 2^32.
  assign pc_next          = pc + 32'd4;
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  // In DISCARD the old request must stay on the bus until it is acked,
  // even though pc already points at the redirect target.
  assign imem_addr = (state == DISCARD) ? req_addr : pc;
  assign imem_req  = rst_n && (state != HOLD);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      skid_instr <= NOP_INSTR;
      skid_pc4   <= 32'd0;
      instr_id   <= NOP_INSTR;
      pc4_id     <= 32'd0;
      valid_id   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            // Any data arriving this cycle belongs to the old path.
            pc       <= redirect_aligned;
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
            if (!imem_ack) begin
              req_addr <= pc;
              state    <= DISCARD;
            end
          end else if (flush_id) begin
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
            if (imem_ack) begin
              pc <= pc_next;
            end
          end else if (imem_ack) begin
            pc <= pc_next;
            if (stall_id) begin
              skid_instr <= imem_rdata;
              skid_pc4   <= pc_next;
              state      <= HOLD;
            end else begin
              instr_id <= imem_rdata;
              pc4_id   <= pc_next;
              valid_id <= 1'b1;
            end
          end else if (!stall_id) begin
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
          end
        end

        HOLD: begin
          if (redirect) begin
            pc       <= redirect_aligned;
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
            state    <= FETCH;
          end else if (flush_id) begin
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
            state    <= FETCH;
          end else if (!stall_id) begin
            instr_id <= skid_instr;
            pc4_id   <= skid_pc4;
            valid_id <= 1'b1;
            state    <= FETCH;
          end
        end

        DISCARD: begin
          // Nothing useful reaches IF/ID here; it either holds or bubbles.
          if (redirect) begin
            pc <= redirect_aligned;
          end
          if (redirect || flush_id || !stall_id) begin
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
          end
          if (imem_ack) begin
            state <= FETCH;
          end
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
